// File: rtl/rr_mux_feeder_if.sv
// rr_mux_feeder_if
// Bundles the two input streams, the output stream and the occupancy
// taps of the round-robin feeder.
//   A, A_valid, A_ready : channel A 2-bit word stream
//   B, B_valid, B_ready : channel B 2-bit word stream
//   Y, Y_valid, Y_ready : registered output word stream
//   Select              : source of Y (0 = A, 1 = B)
//   A_count, B_count    : per-channel FIFO occupancy
// The master modport is the feeder's view; slave is the surrounding
// environment (producers on A/B, consumer on Y).
interface rr_mux_feeder_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [1:0]       A;
  logic             A_valid;
  logic             A_ready;
  logic [1:0]       B;
  logic             B_valid;
  logic             B_ready;
  logic [1:0]       Y;
  logic             Y_valid;
  logic             Y_ready;
  logic             Select;
  logic [CNT_W-1:0] A_count;
  logic [CNT_W-1:0] B_count;

  modport master (
    input  A, A_valid, B, B_valid, Y_ready,
    output A_ready, B_ready, Y, Y_valid, Select, A_count, B_count
  );

  modport slave (
    output A, A_valid, B, B_valid, Y_ready,
    input  A_ready, B_ready, Y, Y_valid, Select, A_count, B_count
  );
endinterface

// File: rtl/rr_mux_feeder.sv
// rr_mux_feeder
// Two-channel buffered round-robin feeder for the 2-bit select-mux
// datapath. Each input stream lands in its own DEPTH-entry FIFO; the
// output stage alternates fairly between non-empty channels and presents
// one registered word per transfer together with Select (0 = A, 1 = B).
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : rr_mux_feeder_if.master (A/B input streams, Y output
//             stream, Select, per-channel occupancy counts)
// DEPTH must be a power of two and at least 2 so the pointers wrap
// naturally at DEPTH-1 -> 0.
module rr_mux_feeder #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  rr_mux_feeder_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  // Per-channel views: index 0 = A, 1 = B.
  logic [1:0]       din      [2];
  logic [1:0]       head     [2];
  logic [CNT_W-1:0] cnt      [2];
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       nonempty;

  logic [1:0] y_reg;
  logic       y_valid_reg;
  logic       select_reg;
  logic       last_grant_reg;
  logic       chosen;
  logic       load;

  assign din[0]      = bus.A;
  assign din[1]      = bus.B;
  assign in_valid[0] = bus.A_valid;
  assign in_valid[1] = bus.B_valid;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [1:0]       mem [DEPTH];
      logic [PTR_W-1:0] wptr_reg;
      logic [PTR_W-1:0] rptr_reg;
      logic [CNT_W-1:0] cnt_reg;

      // Ready looks only at the registered count, so a full FIFO refuses
      // a push even in a cycle where it is also being popped.
      assign in_ready[gi] = reset_n && (cnt_reg != CNT_W'(DEPTH));
      assign push[gi]     = in_valid[gi] && in_ready[gi];
      assign nonempty[gi] = (cnt_reg != '0);
      assign head[gi]     = mem[rptr_reg];
      assign cnt[gi]      = cnt_reg;

      // Storage needs no reset: pointers and count define what is valid.
      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem[wptr_reg] <= din[gi];
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          wptr_reg <= '0;
          rptr_reg <= '0;
          cnt_reg  <= '0;
        end else begin
          if (push[gi]) begin
            wptr_reg <= wptr_reg + 1'b1;
          end
          if (pop[gi]) begin
            rptr_reg <= rptr_reg + 1'b1;
          end
          case ({push[gi], pop[gi]})
            2'b10:   cnt_reg <= cnt_reg + 1'b1;
            2'b01:   cnt_reg <= cnt_reg - 1'b1;
            default: cnt_reg <= cnt_reg;
          endcase
        end
      end
    end
  endgenerate

  // With both channels holding data, hand the grant to the one that did
  // not win last time; otherwise take whichever one has data (the value
  // when both are empty is irrelevant because load is then low).
  assign chosen = (&nonempty) ? ~last_grant_reg : ~nonempty[0];
  assign load   = (!y_valid_reg || bus.Y_ready) && (|nonempty);
  assign pop    = load ? (chosen ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_reg          <= '0;
      y_valid_reg    <= 1'b0;
      select_reg     <= 1'b0;
      last_grant_reg <= 1'b1;  // makes A win the first tie
    end else if (load) begin
      y_reg          <= head[chosen];
      select_reg     <= chosen;
      y_valid_reg    <= 1'b1;
      last_grant_reg <= chosen;
    end else if (y_valid_reg && bus.Y_ready) begin
      // Word consumed and nothing to replace it: Y and Select keep their
      // last values, only the valid flag drops.
      y_valid_reg <= 1'b0;
    end
  end

  assign bus.A_ready = in_ready[0];
  assign bus.B_ready = in_ready[1];
  assign bus.A_count = cnt[0];
  assign bus.B_count = cnt[1];
  assign bus.Y       = y_reg;
  assign bus.Y_valid = y_valid_reg;
  assign bus.Select  = select_reg;
endmodule

// File: tb/tb_rr_mux_feeder.sv
module tb_rr_mux_feeder;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rr_mux_feeder_if #(.DEPTH(DEPTH)) bus ();

  rr_mux_feeder #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  int checks = 0;
  int failures = 0;

  // Scoreboard entries are {Select, Y}.
  logic [2:0] exp_q [$];
  logic [2:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge whenever
  // Y_valid && Y_ready is seen on the falling edge.
  always @(negedge clk) begin
    if (reset_n && bus.Y_valid && bus.Y_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got y=%b sel=%0d expected no word", bus.Y, bus.Select);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("xfer y=%b sel=%0d expect y=%b sel=%0d", bus.Y, bus.Select, mon_exp[1:0], mon_exp[2]);
        chk("out_word", {bus.Select, bus.Y}, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.A = 2'b00;
    bus.B = 2'b00;
    bus.A_valid = 1'b0;
    bus.B_valid = 1'b0;
    bus.Y_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Present one word on a channel and hold it until it is captured.
  task automatic push(input bit ch, input logic [1:0] w);
    int n;
    if (ch) begin
      bus.B = w;
      bus.B_valid = 1'b1;
    end else begin
      bus.A = w;
      bus.A_valid = 1'b1;
    end
    n = 0;
    while (!(ch ? bus.B_ready : bus.A_ready) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: got ready=0 for 50 cycles expected ready=1");
    end
    tick();
    if (ch) bus.B_valid = 1'b0;
    else    bus.A_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.Y_valid) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_y_valid", bus.Y_valid, 0);
  endtask

  logic [1:0] aw [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] bw [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
  logic [1:0] ws [12] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10,
                          2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b01};

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- power-up reset ----------------
    idle_inputs();
    #1;
    chk("rst_y", bus.Y, 0);
    chk("rst_y_valid", bus.Y_valid, 0);
    chk("rst_select", bus.Select, 0);
    chk("rst_a_count", bus.A_count, 0);
    chk("rst_b_count", bus.B_count, 0);
    chk("rst_a_ready", bus.A_ready, 0);
    chk("rst_b_ready", bus.B_ready, 0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("rel_a_ready", bus.A_ready, 1);
    chk("rel_b_ready", bus.B_ready, 1);

    // ---------------- single channel latency ----------------
    do_reset();
    bus.Y_ready = 1'b1;
    exp_q.push_back(3'b010);
    bus.A = 2'b10;
    bus.A_valid = 1'b1;
    tick();                       // edge t: push
    bus.A_valid = 1'b0;
    chk("single_a_count_t", bus.A_count, 1);
    chk("single_y_valid_t", bus.Y_valid, 0);
    tick();                       // edge t+1: load
    chk("single_y", bus.Y, 2'b10);
    chk("single_y_valid", bus.Y_valid, 1);
    chk("single_select", bus.Select, 0);
    chk("single_a_count", bus.A_count, 0);
    tick();                       // edge t+2: consumed
    chk("single_y_valid_drop", bus.Y_valid, 0);
    chk("single_pending", exp_q.size(), 0);

    // ---------------- round-robin ----------------
    do_reset();
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b111);
    exp_q.push_back(3'b011);
    bus.A = 2'b01; bus.B = 2'b00; bus.A_valid = 1'b1; bus.B_valid = 1'b1;
    tick();
    bus.A = 2'b10; bus.B = 2'b11;
    tick();
    bus.A = 2'b11; bus.B_valid = 1'b0;
    tick();
    bus.A_valid = 1'b0;
    chk("rr_hold_word", {bus.Select, bus.Y}, 3'b001);
    chk("rr_a_count", bus.A_count, 2);
    chk("rr_b_count", bus.B_count, 2);
    bus.Y_ready = 1'b1;
    wait_drain(20);

    // ---------------- full FIFO ----------------
    do_reset();
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b101);
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b111);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b101);
    push(1'b1, 2'b00);            // goes straight to Y
    push(1'b1, 2'b01);
    push(1'b1, 2'b10);
    push(1'b1, 2'b11);
    push(1'b1, 2'b00);
    chk("full_b_count", bus.B_count, DEPTH);
    chk("full_b_ready", bus.B_ready, 0);
    bus.B = 2'b01;
    bus.B_valid = 1'b1;
    repeat (2) begin
      tick();
      chk("full_refuse_count", bus.B_count, DEPTH);
      chk("full_refuse_ready", bus.B_ready, 0);
    end
    bus.Y_ready = 1'b1;
    tick();                       // first pop, push still refused
    chk("full_after_pop_count", bus.B_count, 3);
    chk("full_after_pop_ready", bus.B_ready, 1);
    tick();                       // held word captured
    bus.B_valid = 1'b0;
    wait_drain(30);

    // ---------------- backpressure ----------------
    do_reset();
    exp_q.push_back(3'b011);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b1, bw[i]});
      exp_q.push_back({1'b0, aw[i]});
    end
    push(1'b0, 2'b11);
    tick();
    chk("bp_y_valid", bus.Y_valid, 1);
    chk("bp_y", bus.Y, 2'b11);
    for (int k = 0; k < 5; k++) begin
      int m;
      m = (k + 1 > DEPTH) ? DEPTH : k + 1;
      bus.A = aw[(k < 4) ? k : 3];
      bus.B = bw[(k < 4) ? k : 3];
      bus.A_valid = 1'b1;
      bus.B_valid = 1'b1;
      tick();
      chk("bp_stall_word", {bus.Select, bus.Y, bus.Y_valid}, 4'b0111);
      chk("bp_a_count", bus.A_count, m);
      chk("bp_b_count", bus.B_count, m);
    end
    bus.A_valid = 1'b0;
    bus.B_valid = 1'b0;
    bus.Y_ready = 1'b1;
    wait_drain(30);

    // ---------------- pointer wrap ----------------
    do_reset();
    bus.Y_ready = 1'b1;
    bus.A_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.A = ws[i];
      exp_q.push_back({1'b0, ws[i]});
      tick();
      chk("wrap_count_le2", (bus.A_count <= 2), 1);
    end
    bus.A_valid = 1'b0;
    wait_drain(30);

    // ---------------- reset mid-traffic ----------------
    do_reset();
    bus.A = 2'b01; bus.B = 2'b10; bus.A_valid = 1'b1; bus.B_valid = 1'b1;
    tick();
    tick();
    bus.A_valid = 1'b0;
    bus.B_valid = 1'b0;
    chk("mid_pre_y_valid", bus.Y_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_y", bus.Y, 0);
    chk("mid_rst_y_valid", bus.Y_valid, 0);
    chk("mid_rst_select", bus.Select, 0);
    chk("mid_rst_a_count", bus.A_count, 0);
    chk("mid_rst_b_count", bus.B_count, 0);
    chk("mid_rst_a_ready", bus.A_ready, 0);
    chk("mid_rst_b_ready", bus.B_ready, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("mid_rel_a_ready", bus.A_ready, 1);
    chk("mid_rel_b_ready", bus.B_ready, 1);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b110);
    bus.A = 2'b01; bus.B = 2'b10; bus.A_valid = 1'b1; bus.B_valid = 1'b1;
    tick();
    bus.A_valid = 1'b0;
    bus.B_valid = 1'b0;
    bus.Y_ready = 1'b1;
    wait_drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
